// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit-bus to 16-bit-SRAM controller.
package sram_ctrl_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam int BUS_W   = 32;
  localparam logic [BUS_W-1:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  // Word index relative to the SRAM window; addresses below base wrap silently.
  function automatic logic [SRAM_AW-2:0] word_index(input logic [BUS_W-1:0] addr,
                                                    input logic [BUS_W-1:0] base);
    return (SRAM_AW-1)'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Pipeline MEM-stage and SRAM pin bundle; slave is the controller side.
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;

  logic               wr_en;
  logic               rd_en;
  logic [BUS_W-1:0]   address;
  logic [BUS_W-1:0]   write_data;
  logic [BUS_W-1:0]   read_data;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [SRAM_DW-1:0] sram_wdata;
  logic [SRAM_DW-1:0] sram_rdata;
  logic               sram_we_n;

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_rdata,
    output read_data, ready, sram_addr, sram_wdata, sram_we_n
  );

  // The pipeline plus the SRAM device, seen from outside the controller.
  modport master (
    output wr_en, rd_en, address, write_data, sram_rdata,
    input  read_data, ready, sram_addr, sram_wdata, sram_we_n
  );

endinterface

// File: rtl/sram_ctrl_wait_counter.sv
// 3-bit wait-state counter; tc flags the last cycle of a half-access.
module sram_ctrl_wait_counter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [2:0] TC_VALUE = 3'(WAIT_CYCLES);

  logic [2:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= 3'd0;
    end else if (clr) begin
      count_reg <= 3'd0;
    end else if (en) begin
      count_reg <= count_reg + 3'd1;
    end
  end

  assign tc = (count_reg == TC_VALUE);

endmodule

// File: rtl/sram_ctrl.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses with
// configurable wait states, freezing the pipeline via ready meanwhile.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int               WAIT_CYCLES = 1,
  parameter logic [BUS_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input logic        clk,
  input logic        rst,
  sram_ctrl_if.slave bus
);

  state_t             state_reg;
  logic [BUS_W-1:0]   addr_reg;
  logic [BUS_W-1:0]   wdata_reg;
  logic               write_reg;
  logic [BUS_W-1:0]   read_data_reg;
  logic [SRAM_AW-1:0] sram_addr_reg;
  logic [SRAM_DW-1:0] sram_wdata_reg;
  logic               sram_we_n_reg;

  logic cnt_clr;
  logic cnt_en;
  logic cnt_tc;
  logic req;
  logic in_access;

  assign req       = bus.wr_en | bus.rd_en;
  assign in_access = (state_reg == LOW) || (state_reg == HIGH);
  assign cnt_en    = in_access;
  // Clearing on the terminal cycle restarts the count for the next half.
  assign cnt_clr   = !in_access || cnt_tc;

  sram_ctrl_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .tc (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      write_reg      <= 1'b0;
      read_data_reg  <= '0;
      sram_addr_reg  <= '0;
      sram_wdata_reg <= '0;
      sram_we_n_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            addr_reg       <= bus.address;
            wdata_reg      <= bus.write_data;
            write_reg      <= bus.wr_en;
            sram_addr_reg  <= {word_index(bus.address, BASE_ADDR), 1'b0};
            sram_wdata_reg <= bus.wr_en ? bus.write_data[15:0] : '0;
            sram_we_n_reg  <= !bus.wr_en;
            state_reg      <= LOW;
          end
        end
        LOW: begin
          if (cnt_tc) begin
            if (!write_reg) read_data_reg[15:0] <= bus.sram_rdata;
            sram_addr_reg  <= {word_index(addr_reg, BASE_ADDR), 1'b1};
            sram_wdata_reg <= write_reg ? wdata_reg[31:16] : '0;
            state_reg      <= HIGH;
          end
        end
        HIGH: begin
          if (cnt_tc) begin
            if (!write_reg) read_data_reg[31:16] <= bus.sram_rdata;
            sram_addr_reg  <= '0;
            sram_wdata_reg <= '0;
            sram_we_n_reg  <= 1'b1;
            state_reg      <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Held in reset the pipeline must never freeze.
  assign bus.ready      = !rst || (state_reg == DONE) || ((state_reg == IDLE) && !req);
  assign bus.read_data  = read_data_reg;
  assign bus.sram_addr  = sram_addr_reg;
  assign bus.sram_wdata = sram_wdata_reg;
  assign bus.sram_we_n  = sram_we_n_reg;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: SRAM model, write-beat and read-data scoreboards.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_ctrl_if bus ();
  sram_ctrl_if bus0 ();

  sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  sram_ctrl #(.WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  logic [15:0] mem [0:262143];
  assign bus.sram_rdata  = mem[bus.sram_addr];
  assign bus0.sram_rdata = mem[bus0.sram_addr];

  always @(posedge clk) begin
    if (rst === 1'b1 && bus.sram_we_n === 1'b0) mem[bus.sram_addr] = bus.sram_wdata;
  end

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
  } beat_t;

  beat_t       wr_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rd = 32'h0;
  beat_t       mon_beat;
  logic [31:0] exp_rd;

  // Every SRAM write strobe must match the next expected beat.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.sram_we_n === 1'b0) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL strobe: unexpected write addr=%h data=%h, required none",
                 bus.sram_addr, bus.sram_wdata);
      end else begin
        mon_beat = wr_q.pop_front();
        if ({bus.sram_addr, bus.sram_wdata} !== mon_beat) begin
          errors++;
          $display("FAIL write_beat: got addr=%h data=%h, required addr=%h data=%h",
                   bus.sram_addr, bus.sram_wdata, mon_beat.addr, mon_beat.data);
        end
      end
    end
  end

  task automatic push_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] diff;
    diff = a - 32'd1024;
    repeat (2) wr_q.push_back({diff[18:2], 1'b0, d[15:0]});
    repeat (2) wr_q.push_back({diff[18:2], 1'b1, d[31:16]});
  endtask

  task automatic wait_done(output int lows);
    lows = 0;
    while (bus.ready !== 1'b1 && lows < 20) begin
      lows++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.address = 32'd1024; bus.write_data = 32'h1111_2222;
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.address = '0; bus0.write_data = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", bus.ready); end
    checks++; if (bus.sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b required 1", bus.sram_we_n); end
    checks++; if (bus.sram_addr !== 18'h0) begin errors++; $display("FAIL reset_addr: got %h required 0", bus.sram_addr); end
    checks++; if (bus.sram_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata: got %h required 0", bus.sram_wdata); end
    checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data: got %h required 0", bus.read_data); end
    @(negedge clk);
    bus.wr_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    $display("reset: done");
  endtask

  task automatic test_write();
    int n;
    push_write(32'd1024, 32'hDEAD_BEEF);
    rd_q.push_back(model_rd);
    bus.wr_en = 1'b1; bus.address = 32'd1024; bus.write_data = 32'hDEAD_BEEF;
    #1;
    wait_done(n);
    checks++; if (n != 5) begin errors++; $display("FAIL write_latency: got %0d required 5", n); end
    exp_rd = rd_q.pop_front();
    checks++; if (bus.read_data !== exp_rd) begin errors++; $display("FAIL write_keeps_rd: got %h required %h", bus.read_data, exp_rd); end
    bus.wr_en = 1'b0;
    @(negedge clk);
    $display("write 1024 <= deadbeef: low=%0d", n);
  endtask

  task automatic test_read(input logic [31:0] a, input logic [31:0] value, input bit disturb);
    int n;
    int first;
    model_rd = value;
    rd_q.push_back(model_rd);
    bus.rd_en = 1'b1; bus.address = a;
    #1;
    first = 0;
    if (disturb) begin
      // Request lines scrambled after detection must not affect the access.
      first = 1;
      @(negedge clk);
      bus.rd_en = 1'b0; bus.address = 32'hFFFF_FFFF; bus.write_data = 32'h5555_AAAA;
    end
    wait_done(n);
    n += first;
    checks++; if (n != 5) begin errors++; $display("FAIL read_latency: got %0d required 5", n); end
    exp_rd = rd_q.pop_front();
    checks++; if (bus.read_data !== exp_rd) begin errors++; $display("FAIL read_data: got %h required %h", bus.read_data, exp_rd); end
    bus.rd_en = 1'b0;
    @(negedge clk);
    $display("read %0d => %h: low=%0d", a, bus.read_data, n);
  endtask

  task automatic test_rw_conflict();
    int n;
    push_write(32'd1028, 32'h0000_CAFE);
    rd_q.push_back(model_rd);
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.address = 32'd1028; bus.write_data = 32'h0000_CAFE;
    #1;
    wait_done(n);
    checks++; if (n != 5) begin errors++; $display("FAIL rw_latency: got %0d required 5", n); end
    exp_rd = rd_q.pop_front();
    checks++; if (bus.read_data !== exp_rd) begin errors++; $display("FAIL rw_keeps_rd: got %h required %h", bus.read_data, exp_rd); end
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    @(negedge clk);
    $display("rd+wr 1028 <= 0000cafe: low=%0d", n);
  endtask

  task automatic test_wait0();
    int n;
    bus0.rd_en = 1'b1; bus0.address = 32'd1024;
    #1;
    n = 0;
    while (bus0.ready !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n != 3) begin errors++; $display("FAIL wait0_latency: got %0d required 3", n); end
    checks++; if (bus0.read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wait0_data: got %h required deadbeef", bus0.read_data); end
    checks++; if (bus0.sram_we_n !== 1'b1) begin errors++; $display("FAIL wait0_we_n: got %b required 1", bus0.sram_we_n); end
    bus0.rd_en = 1'b0;
    @(negedge clk);
    $display("wait0 read 1024 => %h: low=%0d", bus0.read_data, n);
  endtask

  task automatic test_reset_abort();
    wr_q.push_back({17'h0, 1'b0, 16'h5A5A});
    wr_q.push_back({17'h0, 1'b0, 16'h5A5A});
    bus.wr_en = 1'b1; bus.address = 32'd1024; bus.write_data = 32'hA5A5_5A5A;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.sram_we_n !== 1'b1) begin errors++; $display("FAIL abort_we_n: got %b required 1", bus.sram_we_n); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b required 1", bus.ready); end
    checks++; if (bus.sram_addr !== 18'h0) begin errors++; $display("FAIL abort_addr: got %h required 0", bus.sram_addr); end
    bus.wr_en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL abort_beats: got %0d pending required 0", wr_q.size()); end
    $display("reset abort: we_n=%b", bus.sram_we_n);
  endtask

  task automatic test_back_to_back();
    int n;
    mem[18'h3FE00] = 16'hBEAD;
    mem[18'h3FE01] = 16'hFACE;
    model_rd = 32'hFACE_BEAD;
    rd_q.push_back(model_rd);
    rd_q.push_back(model_rd);
    bus.rd_en = 1'b1; bus.address = 32'd0;
    #1;
    wait_done(n);
    checks++; if (n != 5) begin errors++; $display("FAIL b2b_latency1: got %0d required 5", n); end
    exp_rd = rd_q.pop_front();
    checks++; if (bus.read_data !== exp_rd) begin errors++; $display("FAIL b2b_data1: got %h required %h", bus.read_data, exp_rd); end
    @(negedge clk);
    #1;
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL b2b_restart: got ready %b required 0", bus.ready); end
    checks++; if (bus.sram_addr !== 18'h0) begin errors++; $display("FAIL b2b_idle_addr: got %h required 0", bus.sram_addr); end
    wait_done(n);
    checks++; if (n != 5) begin errors++; $display("FAIL b2b_latency2: got %0d required 5", n); end
    exp_rd = rd_q.pop_front();
    checks++; if (bus.read_data !== exp_rd) begin errors++; $display("FAIL b2b_data2: got %h required %h", bus.read_data, exp_rd); end
    bus.rd_en = 1'b0;
    @(negedge clk);
    $display("back-to-back read 0 => %h: low=%0d", bus.read_data, n);
  endtask

  initial begin
    mem[4] = 16'h5678;
    mem[5] = 16'h1234;
    test_reset();
    test_write();
    test_read(32'd1024, 32'hDEAD_BEEF, 1'b0);
    test_read(32'd1032, 32'h1234_5678, 1'b1);
    test_rw_conflict();
    test_wait0();
    test_reset_abort();
    test_read(32'd1032, 32'h1234_5678, 1'b0);
    test_back_to_back();
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL beats_left: got %0d required 0", wr_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
